// File: rtl/snitch_acc_issuer.sv
// Core-side offload initiator: one-entry request register toward the accelerator, per-rd busy
// scoreboard with an outstanding-op counter, and a zero-latency response-to-writeback path.
module snitch_acc_issuer #(
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    issue_valid_i,
  output logic                    issue_ready_o,
  input  logic [31:0]             issue_op_i,
  input  logic [IdWidth-1:0]      issue_rd_i,
  input  logic [31:0]             issue_arga_i,
  input  logic [31:0]             issue_argb_i,
  input  logic [31:0]             issue_argc_i,
  output logic [31:0]             acc_qaddr_o,
  output logic [IdWidth-1:0]      acc_qid_o,
  output logic [31:0]             acc_qdata_op_o,
  output logic [31:0]             acc_qdata_arga_o,
  output logic [31:0]             acc_qdata_argb_o,
  output logic [31:0]             acc_qdata_argc_o,
  output logic                    acc_qvalid_o,
  input  logic                    acc_qready_i,
  input  logic [31:0]             acc_pdata_i,
  input  logic [IdWidth-1:0]      acc_pid_i,
  input  logic                    acc_perror_i,
  input  logic                    acc_pvalid_i,
  output logic                    acc_pready_o,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [IdWidth-1:0]      wb_rd_o,
  output logic [31:0]             wb_data_o,
  output logic                    wb_error_o,
  output logic [2**IdWidth-1:0]   sb_busy_o,
  output logic                    idle_o,
  output logic                    spurious_o
);

  localparam int unsigned NumRegs  = 2**IdWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic                 qvalid_q, qvalid_d;
  logic [IdWidth-1:0]   qid_q;
  logic [31:0]          qop_q, qarga_q, qargb_q, qargc_q;
  logic [NumRegs-1:0]   busy_q, busy_d, set_mask, clr_mask;
  logic [CntWidth-1:0]  count_q, count_d;
  logic                 spurious_q, spurious_d;
  logic                 issue_hs, wb_hs, slot_free;

  // Ready is forced low while reset is asserted so nothing is offered as accepted during reset.
  assign slot_free     = !qvalid_q | acc_qready_i;
  assign issue_ready_o = rst_ni & slot_free & !busy_q[issue_rd_i] & (count_q < MaxCnt);
  assign issue_hs      = issue_valid_i & issue_ready_o;
  assign wb_hs         = acc_pvalid_i & wb_ready_i;

  assign acc_qaddr_o      = '0;
  assign acc_qvalid_o     = qvalid_q;
  assign acc_qid_o        = qid_q;
  assign acc_qdata_op_o   = qop_q;
  assign acc_qdata_arga_o = qarga_q;
  assign acc_qdata_argb_o = qargb_q;
  assign acc_qdata_argc_o = qargc_q;

  assign wb_valid_o   = acc_pvalid_i;
  assign acc_pready_o = wb_ready_i;
  assign wb_rd_o      = acc_pid_i;
  assign wb_data_o    = acc_pdata_i;
  assign wb_error_o   = acc_perror_i;

  assign sb_busy_o  = busy_q;
  assign idle_o     = (count_q == '0);
  assign spurious_o = spurious_q;

  // x0 is never tracked: writes to it are discarded, so it can never cause a hazard.
  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_sb
    assign set_mask[gi] = (gi != 0) && issue_hs && (issue_rd_i == IdWidth'(gi));
    assign clr_mask[gi] = wb_hs && (acc_pid_i == IdWidth'(gi));
  end

  always_comb begin
    qvalid_d   = qvalid_q;
    busy_d     = (busy_q & ~clr_mask) | set_mask;
    count_d    = count_q;
    spurious_d = spurious_q;
    if (issue_hs) begin
      qvalid_d = 1'b1;
    end else if (acc_qready_i) begin
      qvalid_d = 1'b0;
    end
    if (issue_hs && !wb_hs) begin
      count_d = count_q + 1'b1;
    end else if (!issue_hs && wb_hs && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
    if (wb_hs && (acc_pid_i != '0) && !busy_q[acc_pid_i]) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qvalid_q   <= 1'b0;
      qid_q      <= '0;
      qop_q      <= '0;
      qarga_q    <= '0;
      qargb_q    <= '0;
      qargc_q    <= '0;
      busy_q     <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      qvalid_q   <= qvalid_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
      if (issue_hs) begin
        qid_q   <= issue_rd_i;
        qop_q   <= issue_op_i;
        qarga_q <= issue_arga_i;
        qargb_q <= issue_argb_i;
        qargc_q <= issue_argc_i;
      end
    end
  end

endmodule
